// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the multi-port register
//               file (sweep FSM state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Sweep controller states: CLEAR zeroes the array after reset, IDLE serves requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One read port of the register file: register-0 masking,
//               same-cycle write forwarding and the registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_capture,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_raw,
    input  logic              i_wr_acc,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] r_rd_data;

    // Pick the value to capture: array contents, forwarded write data, or forced zero for r0.
    always_comb begin
        w_sel = i_rd_raw;
        if ((BYPASS != 0) && i_wr_acc && (i_wr_addr == i_rd_addr)) begin
            w_sel = i_wr_data;
        end
        if ((ZERO_REG != 0) && (i_rd_addr == '0)) begin
            w_sel = '0;
        end
    end

    // Output register; holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_capture) begin
            r_rd_data <= w_sel;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parameterised multi-read-port register file with a single
//               write port, post-reset clear sweep and done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_done,
    input  logic                     rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_done,
    output logic                     busy
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_wr_done;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_wr_acc;
    logic w_rd_acc;

    // Requests are only honoured out of reset, in IDLE, with the block enabled.
    assign w_idle   = (r_state == IDLE);
    assign wr_ready = rst_n && w_idle && en;
    assign busy     = !rst_n || (r_state == CLEAR);
    assign w_wr_acc = wr_valid && wr_ready;
    assign w_rd_acc = rd_valid && en && w_idle && rst_n;

    // Sweep controller and done-pulse generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_idx     <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_idx     <= r_idx + 1'b1;
                    r_wr_done <= 1'b0;
                    r_rd_done <= 1'b0;
                    if (r_idx == c_LAST) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_wr_done <= w_wr_acc;
                    r_rd_done <= w_rd_acc;
                end
                default: begin
                    r_state <= CLEAR;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Storage array: zeroed one entry per cycle during the sweep, then normal writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == CLEAR) begin
                r_mem[r_idx] <= '0;
            end else if (w_wr_acc && !((ZERO_REG != 0) && (wr_addr == '0))) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign wr_done = r_wr_done;
    assign rd_done = r_rd_done;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_capture (w_rd_acc),
            .i_rd_addr (w_addr),
            .i_rd_raw  (r_mem[w_addr]),
            .i_wr_acc  (w_wr_acc),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_rd_data (rd_data[gi*DATA_W +: DATA_W])
        );
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances share the
//               stimulus: A uses defaults (ZERO_REG=1, BYPASS=1), B uses
//               ZERO_REG=0, BYPASS=0. A behavioural array model predicts both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, en, wr_valid, rd_valid;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NR*AW-1:0] rd_addr;

    logic             wr_ready_a, wr_done_a, rd_done_a, busy_a;
    logic [NR*DW-1:0] rd_data_a;
    logic             wr_ready_b, wr_done_b, rd_done_b, busy_b;
    logic [NR*DW-1:0] rd_data_b;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done_a), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_done(rd_done_a), .busy(busy_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done_b), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_done(rd_done_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: plain arrays plus a count of sweep cycles remaining.
    logic [DW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_b [DEPTH];
    logic [DW-1:0] e_rd_a [NR];
    logic [DW-1:0] e_rd_b [NR];
    logic          e_wd, e_rdn;
    int            busy_left = DEPTH;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic r, input logic e, input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic rv,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic [AW-1:0] ra [NR];
        ra[0] = ra0;
        ra[1] = ra1;
        rst_n    = r;
        en       = e;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = {ra1, ra0};
        #1;
        check("wr_ready_a", 64'(wr_ready_a), 64'(r && busy_left == 0 && e));
        check("wr_ready_b", 64'(wr_ready_b), 64'(r && busy_left == 0 && e));
        check("busy_a", 64'(busy_a), 64'(!r || busy_left > 0));
        check("busy_b", 64'(busy_b), 64'(!r || busy_left > 0));

        if (!r) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            for (int p = 0; p < NR; p++) begin
                e_rd_a[p] = '0;
                e_rd_b[p] = '0;
            end
            e_wd  = 1'b0;
            e_rdn = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            e_wd  = 1'b0;
            e_rdn = 1'b0;
        end else begin
            e_wd  = wv && e;
            e_rdn = rv && e;
            if (e_rdn) begin
                for (int p = 0; p < NR; p++) begin
                    if (ra[p] == 0)                 e_rd_a[p] = '0;
                    else if (e_wd && wa == ra[p])   e_rd_a[p] = wd;
                    else                            e_rd_a[p] = m_a[ra[p]];
                    e_rd_b[p] = m_b[ra[p]];
                end
            end
            if (e_wd) begin
                if (wa != 0) m_a[wa] = wd;
                m_b[wa] = wd;
            end
        end

        @(posedge clk);
        #1;
        check("wr_done_a", 64'(wr_done_a), 64'(e_wd));
        check("wr_done_b", 64'(wr_done_b), 64'(e_wd));
        check("rd_done_a", 64'(rd_done_a), 64'(e_rdn));
        check("rd_done_b", 64'(rd_done_b), 64'(e_rdn));
        for (int p = 0; p < NR; p++) begin
            check($sformatf("rd_data_a[%0d]", p), 64'(rd_data_a[p*DW +: DW]), 64'(e_rd_a[p]));
            check($sformatf("rd_data_b[%0d]", p), 64'(rd_data_b[p*DW +: DW]), 64'(e_rd_b[p]));
        end
    endtask

    // Count cycles with busy high after a reset step; bounded so it always ends.
    task automatic measure_sweep(input string name);
        int cnt;
        cnt = 0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            if (busy_a) cnt++;
            step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        end
        check(name, 64'(cnt), 64'(DEPTH));
    endtask

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          x_wd;
        logic          x_rd;
        logic [DW-1:0] x0;
        logic [DW-1:0] x1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Directed vectors, expected values for instance A (ZERO_REG=1, BYPASS=1).
        tbl[0] = '{1, 5'd1, 32'd100,        0, 5'd0, 5'd0, 1, 0, 32'd0,        32'd0};
        tbl[1] = '{1, 5'd2, 32'd200,        0, 5'd0, 5'd0, 1, 0, 32'd0,        32'd0};
        tbl[2] = '{0, 5'd0, 32'd0,          1, 5'd1, 5'd2, 0, 1, 32'd100,      32'd200};
        tbl[3] = '{1, 5'd0, 32'd50,         0, 5'd0, 5'd0, 1, 0, 32'd0,        32'd0};
        tbl[4] = '{0, 5'd0, 32'd0,          1, 5'd0, 5'd0, 0, 1, 32'd0,        32'd0};
        tbl[5] = '{1, 5'd5, 32'hDEADBEEF,   1, 5'd5, 5'd5, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[6] = '{0, 5'd0, 32'd0,          1, 5'd5, 5'd1, 0, 1, 32'hDEADBEEF, 32'd100};

        // Reset, then the sweep must last exactly DEPTH cycles.
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 5'd4, 32'h1234, 1'b1, 5'd4, 5'd4);
        measure_sweep("sweep_len_initial");

        // Every register reads zero after the sweep.
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, AW'(i), AW'(DEPTH - i));
        end

        // Table-driven directed sequence.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra0, tbl[i].ra1);
            check($sformatf("tbl%0d_wr_done", i), 64'(wr_done_a), 64'(tbl[i].x_wd));
            check($sformatf("tbl%0d_rd_done", i), 64'(rd_done_a), 64'(tbl[i].x_rd));
            if (tbl[i].x_rd) begin
                check($sformatf("tbl%0d_d0", i), 64'(rd_data_a[0 +: DW]), 64'(tbl[i].x0));
                check($sformatf("tbl%0d_d1", i), 64'(rd_data_a[DW +: DW]), 64'(tbl[i].x1));
            end
        end
        // Instance B kept the r0 write and returned the pre-write r5 value.
        check("b_r0_kept", 64'(m_b[0]), 64'(32'd50));

        // Disabled block: requests ignored, nothing pending.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 5'd3);
        end
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3);
        check("en0_r3_zero", 64'(rd_data_a[0 +: DW]), 64'd0);

        // Reset in the middle of a sweep restarts it from zero.
        step(1'b1, 1'b1, 1'b1, 5'd1, 32'h11, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b1, 5'd1, 32'h22, 1'b1, 5'd1, 5'd1);
        end
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        measure_sweep("sweep_len_restart");
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 5'd1, 5'd1);
        check("restart_r1_zero", 64'(rd_data_a[0 +: DW]), 64'd0);

        // Randomised traffic on a small address range to force collisions.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)),
                 $urandom(),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
